// File: rtl/rca_dispatch_control_pkg.sv
// Shared types and defaults for the RCA dispatch controller.
//   - Default geometry (RCA count, ID depth, operand ports, operand width).
//   - rca_sel_t / rca_id_t: RCA selector and instruction ID types for the default geometry.
//   - rca_dispatch_state_t: dispatch FSM states {ACCEPT, DRAIN, SWITCH}.
//   - rca_req_buf_t: layout of one buffered RCA-use request.
//   - sat_inc32: saturating 32-bit increment used by the optional perf counters.
package rca_dispatch_control_pkg;

    localparam int unsigned DEF_NUM_RCAS       = 4;
    localparam int unsigned DEF_MAX_IDS        = 8;
    localparam int unsigned DEF_NUM_READ_PORTS = 5;
    localparam int unsigned DEF_XLEN           = 32;

    typedef logic [$clog2(DEF_NUM_RCAS)-1:0] rca_sel_t;
    typedef logic [$clog2(DEF_MAX_IDS)-1:0]  rca_id_t;

    typedef enum logic [1:0] {
        ACCEPT,
        DRAIN,
        SWITCH
    } rca_dispatch_state_t;

    typedef struct packed {
        rca_id_t                                      id;
        logic                                         fb;
        rca_sel_t                                     sel;
        logic [DEF_NUM_READ_PORTS-1:0][DEF_XLEN-1:0] rs;
    } rca_req_buf_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rca_dispatch_control_id_tracker.sv
// In-flight ID tracker for the RCA dispatch controller.
// Keeps dispatched IDs in issue order, counts occupancy and remembers the feedback flag
// of each ID so writeback can see it for the head entry.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push, id_in,     enqueue id_in and record fb_in for that ID
//   fb_in
//   pop              retire the head entry (ignored when empty)
//   head_id, head_fb oldest in-flight ID and its feedback flag
//   occupancy        number of IDs in flight (0..MAX_IDS)
//   full, empty      occupancy == MAX_IDS / occupancy == 0
module rca_dispatch_control_id_tracker #(
    parameter int unsigned MAX_IDS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [$clog2(MAX_IDS)-1:0] id_in,
    input  logic                       fb_in,
    output logic [$clog2(MAX_IDS)-1:0] head_id,
    output logic                       head_fb,
    output logic [$clog2(MAX_IDS):0]   occupancy,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned IdW  = $clog2(MAX_IDS);
    localparam int unsigned CntW = IdW + 1;

    logic [IdW-1:0]     id_mem_q [MAX_IDS];
    logic [MAX_IDS-1:0] fb_q;
    logic [IdW-1:0]     wr_ptr_q;
    logic [IdW-1:0]     rd_ptr_q;
    logic [CntW-1:0]    count_q;
    logic               do_push;
    logic               do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CntW'(MAX_IDS));
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign occupancy = count_q;
    assign head_id   = id_mem_q[rd_ptr_q];
    assign head_fb   = fb_q[head_id];

    // MAX_IDS is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fb_q     <= '0;
            for (int i = 0; i < int'(MAX_IDS); i++) begin
                id_mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                id_mem_q[wr_ptr_q] <= id_in;
                fb_q[id_in]        <= fb_in;
                wr_ptr_q           <= wr_ptr_q + IdW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + IdW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/rca_dispatch_control.sv
// Issue-side controller for a grid of NUM_RCAS reconfigurable accelerators.
// Buffers one RCA-use request, dispatches it to the RCA owning the grid, and tracks
// in-flight IDs for writeback. Retargeting to another RCA while work is in flight drains
// that work first, then issues with a one-cycle IO FIFO clear.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   new_request       issue handshake accepted this cycle
//   ready             unit can accept a request
//   req_id/use/fb/sel request ID, RCA-use flag, feedback flag, target RCA
//   req_rs            request operands
//   wb_committing     head ID retired this cycle
//   wb_id, wb_fb_instr oldest in-flight ID and its feedback flag (valid with fifo_populated)
//   fifo_populated    at least one ID in flight
//   dispatch_valid    buffered request issues to the grid this cycle
//   dispatch_rs       buffered operands
//   clear_fifos       one-cycle pulse flushing the IO FIFOs / LS counters
//   active_rca        RCA currently owning the grid
//   perf_switches     RCA switch count (0 unless RCA_DISPATCH_PERF_EN)
//   perf_drain_cyc    cycles spent draining (0 unless RCA_DISPATCH_PERF_EN)
// Build option: define RCA_DISPATCH_PERF_EN to include the saturating perf counters.
module rca_dispatch_control
    import rca_dispatch_control_pkg::*;
#(
    parameter int unsigned NUM_RCAS       = DEF_NUM_RCAS,
    parameter int unsigned MAX_IDS        = DEF_MAX_IDS,
    parameter int unsigned NUM_READ_PORTS = DEF_NUM_READ_PORTS,
    parameter int unsigned XLEN           = DEF_XLEN
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  new_request,
    output logic                                  ready,
    input  logic [$clog2(MAX_IDS)-1:0]            req_id,
    input  logic                                  req_use,
    input  logic                                  req_fb,
    input  logic [$clog2(NUM_RCAS)-1:0]           req_sel,
    input  logic [NUM_READ_PORTS-1:0][XLEN-1:0]   req_rs,
    input  logic                                  wb_committing,
    output logic [$clog2(MAX_IDS)-1:0]            wb_id,
    output logic                                  wb_fb_instr,
    output logic                                  fifo_populated,
    output logic                                  dispatch_valid,
    output logic [NUM_READ_PORTS-1:0][XLEN-1:0]   dispatch_rs,
    output logic                                  clear_fifos,
    output logic [$clog2(NUM_RCAS)-1:0]           active_rca,
    output logic [31:0]                           perf_switches,
    output logic [31:0]                           perf_drain_cyc
);

    localparam int unsigned IdW  = $clog2(MAX_IDS);
    localparam int unsigned SelW = $clog2(NUM_RCAS);
    localparam int unsigned CntW = IdW + 1;

    rca_dispatch_state_t state_q, state_d;

    logic                                buf_valid_q;
    logic [IdW-1:0]                      buf_id_q;
    logic                                buf_fb_q;
    logic [SelW-1:0]                     buf_sel_q;
    logic [NUM_READ_PORTS-1:0][XLEN-1:0] buf_rs_q;
    logic [SelW-1:0]                     active_rca_q;
    logic                                active_valid_q;

    logic [CntW-1:0] occupancy;
    logic            occ_zero;
    logic            sel_match;
    logic            capture;
    logic            trk_full;
    logic            trk_empty;

    assign capture   = new_request && req_use;
    assign occ_zero  = (occupancy == '0);
    assign sel_match = (buf_sel_q == active_rca_q);

    rca_dispatch_control_id_tracker #(
        .MAX_IDS (MAX_IDS)
    ) u_id_tracker (
        .clk       (clk),
        .rst       (rst),
        .push      (dispatch_valid),
        .pop       (wb_committing),
        .id_in     (buf_id_q),
        .fb_in     (buf_fb_q),
        .head_id   (wb_id),
        .head_fb   (wb_fb_instr),
        .occupancy (occupancy),
        .full      (trk_full),
        .empty     (trk_empty)
    );

    assign fifo_populated = !trk_empty;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCEPT: begin
                if (buf_valid_q && !sel_match && !occ_zero) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (occ_zero) begin
                    state_d = SWITCH;
                end
            end
            SWITCH:  state_d = ACCEPT;
            default: state_d = ACCEPT;
        endcase
    end

    // FSM outputs. An idle grid (occupancy 0) can be retargeted without draining; a clear is
    // still required whenever the owner changes or the grid has never been claimed.
    always_comb begin
        dispatch_valid = 1'b0;
        clear_fifos    = 1'b0;
        unique case (state_q)
            ACCEPT: begin
                if (buf_valid_q && (sel_match || occ_zero)) begin
                    dispatch_valid = 1'b1;
                    clear_fifos    = (occ_zero && !sel_match) || !active_valid_q;
                end
            end
            SWITCH: begin
                dispatch_valid = 1'b1;
                clear_fifos    = 1'b1;
            end
            default: ;
        endcase
    end

    // Counting the buffered request against capacity guarantees a dispatch never meets a
    // full tracker.
    always_comb begin
        ready = (state_q == ACCEPT)
             && (!buf_valid_q || dispatch_valid)
             && ((occupancy + CntW'(buf_valid_q)) < CntW'(MAX_IDS));
    end

    // Request buffer and grid ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q    <= 1'b0;
            buf_id_q       <= '0;
            buf_fb_q       <= 1'b0;
            buf_sel_q      <= '0;
            buf_rs_q       <= '0;
            active_rca_q   <= '0;
            active_valid_q <= 1'b0;
        end else begin
            if (capture) begin
                buf_valid_q <= 1'b1;
                buf_id_q    <= req_id;
                buf_fb_q    <= req_fb;
                buf_sel_q   <= req_sel;
                buf_rs_q    <= req_rs;
            end else if (dispatch_valid) begin
                buf_valid_q <= 1'b0;
            end
            if (dispatch_valid) begin
                active_rca_q   <= buf_sel_q;
                active_valid_q <= 1'b1;
            end
        end
    end

    assign dispatch_rs = buf_rs_q;
    assign active_rca  = active_rca_q;

`ifdef RCA_DISPATCH_PERF_EN
    logic [31:0] perf_switches_q;
    logic [31:0] perf_drain_cyc_q;
    logic        count_switch;

    // A first activation is a dispatch before the grid has ever had an owner.
    assign count_switch = (state_q == SWITCH) || (dispatch_valid && !active_valid_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_switches_q  <= '0;
            perf_drain_cyc_q <= '0;
        end else begin
            if (count_switch) begin
                perf_switches_q <= sat_inc32(perf_switches_q);
            end
            if (state_q == DRAIN) begin
                perf_drain_cyc_q <= sat_inc32(perf_drain_cyc_q);
            end
        end
    end

    assign perf_switches  = perf_switches_q;
    assign perf_drain_cyc = perf_drain_cyc_q;
`else
    assign perf_switches  = '0;
    assign perf_drain_cyc = '0;
`endif

endmodule

// File: tb/tb_rca_dispatch_control.sv
`timescale 1ns/1ps
module tb_rca_dispatch_control;

    localparam int unsigned NR   = 4;
    localparam int unsigned MI   = 8;
    localparam int unsigned NP   = 5;
    localparam int unsigned XL   = 32;
    localparam int unsigned IdW  = 3;
    localparam int unsigned SelW = 2;
    localparam int unsigned RsW  = NP * XL;

    typedef logic [NP-1:0][XL-1:0] rs_t;
    typedef struct { rs_t rs; logic clr; } disp_exp_t;
    typedef struct { logic [IdW-1:0] id; logic fb; } wb_exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            new_request = 1'b0;
    logic            ready;
    logic [IdW-1:0]  req_id = '0;
    logic            req_use = 1'b0;
    logic            req_fb = 1'b0;
    logic [SelW-1:0] req_sel = '0;
    rs_t             req_rs = '0;
    logic            wb_committing = 1'b0;
    logic [IdW-1:0]  wb_id;
    logic            wb_fb_instr;
    logic            fifo_populated;
    logic            dispatch_valid;
    rs_t             dispatch_rs;
    logic            clear_fifos;
    logic [SelW-1:0] active_rca;
    logic [31:0]     perf_switches;
    logic [31:0]     perf_drain_cyc;

    disp_exp_t disp_q[$];
    wb_exp_t   wb_q[$];
    int        checks = 0;
    int        errors = 0;

    always #5 clk = ~clk;

    rca_dispatch_control #(
        .NUM_RCAS       (NR),
        .MAX_IDS        (MI),
        .NUM_READ_PORTS (NP),
        .XLEN           (XL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .new_request    (new_request),
        .ready          (ready),
        .req_id         (req_id),
        .req_use        (req_use),
        .req_fb         (req_fb),
        .req_sel        (req_sel),
        .req_rs         (req_rs),
        .wb_committing  (wb_committing),
        .wb_id          (wb_id),
        .wb_fb_instr    (wb_fb_instr),
        .fifo_populated (fifo_populated),
        .dispatch_valid (dispatch_valid),
        .dispatch_rs    (dispatch_rs),
        .clear_fifos    (clear_fifos),
        .active_rca     (active_rca),
        .perf_switches  (perf_switches),
        .perf_drain_cyc (perf_drain_cyc)
    );

    task automatic check(input string name, input logic [RsW-1:0] act, input logic [RsW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rs_t make_rs(input logic [IdW-1:0] id, input logic [SelW-1:0] sel);
        rs_t r;
        for (int p = 0; p < int'(NP); p++) begin
            r[p] = {8'hA0 + 8'(p), 6'h0, sel, 13'h0, id};
        end
        return r;
    endfunction

    // Monitor: compares every dispatch and every commit against the scoreboard queues.
    always @(negedge clk) begin
        disp_exp_t de;
        wb_exp_t   we;
        if (!rst && dispatch_valid) begin
            if (disp_q.size() == 0) begin
                check("unexpected_dispatch", 1, 0);
            end else begin
                de = disp_q.pop_front();
                check("dispatch_rs", dispatch_rs, de.rs);
                check("dispatch_clear", clear_fifos, de.clr);
            end
        end
        if (!rst && wb_committing) begin
            check("wb_populated", fifo_populated, 1);
            if (wb_q.size() == 0) begin
                check("unexpected_commit", 1, 0);
            end else begin
                we = wb_q.pop_front();
                check("wb_id", wb_id, we.id);
                check("wb_fb", wb_fb_instr, we.fb);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after capture.
    task automatic issue(input logic [SelW-1:0] sel, input logic [IdW-1:0] id, input logic fb,
                         input logic exp_clr, input bit exp_dispatch);
        int n = 0;
        req_sel = sel;
        req_id  = id;
        req_fb  = fb;
        req_use = 1'b1;
        req_rs  = make_rs(id, sel);
        while (!ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("issue_ready", ready, 1);
        if (!ready) begin
            req_use = 1'b0;
            return;
        end
        new_request = 1'b1;
        if (exp_dispatch) begin
            disp_q.push_back('{rs: make_rs(id, sel), clr: exp_clr});
            wb_q.push_back('{id: id, fb: fb});
        end
        @(posedge clk);
        #1;
        new_request = 1'b0;
        req_use     = 1'b0;
    endtask

    task automatic commit();
        wb_committing = 1'b1;
        @(posedge clk);
        #1;
        wb_committing = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] exp_sw;
    logic [31:0] exp_dr;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_dispatch_valid", dispatch_valid, 0);
        check("rst_clear", clear_fifos, 0);
        check("rst_active_rca", active_rca, 0);
        check("rst_populated", fifo_populated, 0);
        check("rst_wb_id", wb_id, 0);
        check("rst_wb_fb", wb_fb_instr, 0);
        check("rst_dispatch_rs", dispatch_rs, 0);
        check("rst_perf_sw", perf_switches, 0);
        check("rst_perf_drain", perf_drain_cyc, 0);

        // 1: first activation on RCA 2.
        issue(2'd2, 3'd3, 1'b0, 1'b1, 1'b1);
        check("t1_dispatch_valid", dispatch_valid, 1);
        step(1);
        check("t1_active_rca", active_rca, 2);
        check("t1_wb_id", wb_id, 3);
        check("t1_populated", fifo_populated, 1);
        commit();

        // 2: back-to-back on the same RCA, no clears.
        issue(2'd2, 3'd0, 1'b0, 1'b0, 1'b1);
        issue(2'd2, 3'd1, 1'b1, 1'b0, 1'b1);
        issue(2'd2, 3'd2, 1'b0, 1'b0, 1'b1);
        repeat (3) commit();

        // Non-use request must be ignored.
        req_use     = 1'b0;
        req_sel     = 2'd3;
        new_request = 1'b1;
        step(1);
        new_request = 1'b0;
        step(2);
        check("nonuse_populated", fifo_populated, 0);
        check("nonuse_active_rca", active_rca, 2);

        // 3: idle retarget to RCA 1, then a drain-and-switch to RCA 3.
        issue(2'd1, 3'd4, 1'b1, 1'b1, 1'b1);
        issue(2'd1, 3'd5, 1'b0, 1'b0, 1'b1);
        issue(2'd3, 3'd6, 1'b0, 1'b1, 1'b1);
        check("t3_ready_pending", ready, 0);
        commit();
        commit();
        check("t3_ready_drain", ready, 0);
        step(1);
        check("t3_switch_dispatch", dispatch_valid, 1);
        check("t3_switch_clear", clear_fifos, 1);
        check("t3_switch_ready", ready, 0);
        step(1);
        check("t3_active_rca", active_rca, 3);
        check("t3_ready_after", ready, 1);
`ifdef RCA_DISPATCH_PERF_EN
        exp_sw = 32'd2;
        exp_dr = 32'd2;
`else
        exp_sw = 32'd0;
        exp_dr = 32'd0;
`endif
        check("t3_perf_sw", perf_switches, exp_sw);
        check("t3_perf_drain", perf_drain_cyc, exp_dr);
        commit();

        // 4: fill to capacity without commits.
        for (int i = 0; i < 8; i++) begin
            issue(2'd3, 3'(i), 1'(i % 2), 1'b0, 1'b1);
        end
        check("t4_ready_last", ready, 0);
        step(1);
        check("t4_ready_full", ready, 0);
        check("t4_populated", fifo_populated, 1);
        commit();
        check("t4_ready_after_commit", ready, 1);
        repeat (3) commit();

        // 5: push and commit together at occupancy 4; id 0 now carries fb=1.
        issue(2'd3, 3'd0, 1'b1, 1'b0, 1'b1);
        commit();
        repeat (4) commit();
        check("t5_drained", fifo_populated, 0);
        check("disp_queue_empty", disp_q.size(), 0);
        check("wb_queue_empty", wb_q.size(), 0);

        // 6: reset in DRAIN discards the buffered request.
        issue(2'd3, 3'd1, 1'b0, 1'b0, 1'b1);
        issue(2'd0, 3'd2, 1'b0, 1'b0, 1'b0);
        step(1);
        check("t6_ready_drain", ready, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        disp_q.delete();
        wb_q.delete();
        check("t6_active_rca", active_rca, 0);
        check("t6_ready", ready, 1);
        check("t6_dispatch_valid", dispatch_valid, 0);
        check("t6_clear", clear_fifos, 0);
        check("t6_populated", fifo_populated, 0);
        check("t6_perf_sw", perf_switches, 0);
        check("t6_perf_drain", perf_drain_cyc, 0);
        step(4);
        check("t6_idle_populated", fifo_populated, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
